// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings and FSM states for the HI/LO multiply/divide unit
package hilo_pkg;

    localparam logic [3:0] OP_MTHI  = 4'd0;
    localparam logic [3:0] OP_MTLO  = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_DIV   = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_div_core.sv
// rtl/hilo_div_core.sv - restoring unsigned divide datapath, one quotient bit per step
module hilo_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   trial;

    // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
        end else if (flush) begin
            cnt_q <= '0;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == '0);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO registers with multiply, multiply-accumulate and iterative divide
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] ReadHi,
    output logic [WIDTH-1:0] ReadLo
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dbz_q;
    logic             q_neg_q, r_neg_q;

    logic             accept;
    logic             is_div, is_signed_div, div_zero;
    logic             div_load, div_step, div_write;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] core_quo, core_rem, core_last_q_unused;
    logic [WIDTH-1:0] fix_quo, fix_rem;
    logic             core_last;

    logic             mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, acc;

    assign accept        = Start & ~Busy & ~Flush;
    assign is_div        = (Op == OP_DIV) || (Op == OP_DIVU);
    assign is_signed_div = (Op == OP_DIV);
    assign div_zero      = (OpB == '0);

    assign a_neg = is_signed_div & OpA[WIDTH-1];
    assign b_neg = is_signed_div & OpB[WIDTH-1];
    assign mag_a = a_neg ? (~OpA + WIDTH'(1)) : OpA;
    assign mag_b = b_neg ? (~OpB + WIDTH'(1)) : OpB;

    // Signed/unsigned multiply share one product; sign extension selects the flavour
    assign mul_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign ext_a   = {{WIDTH{mul_signed & OpA[WIDTH-1]}}, OpA};
    assign ext_b   = {{WIDTH{mul_signed & OpB[WIDTH-1]}}, OpB};
    assign product = ext_a * ext_b;
    assign acc     = {hi_q, lo_q};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
        div_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_div && !div_zero) begin
                    div_load = 1'b1;
                    state_d  = ST_DIV;
                end
            end
            ST_DIV: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (core_last) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!Flush) begin
                    div_write = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    hilo_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (div_load),
        .step      (div_step),
        .flush     (Flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_quo),
        .remainder (core_rem),
        .last      (core_last)
    );

    assign core_last_q_unused = '0;
    assign fix_quo = q_neg_q ? (~core_quo + WIDTH'(1)) : core_quo;
    assign fix_rem = r_neg_q ? (~core_rem + WIDTH'(1)) : core_rem;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (div_load) begin
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_write) begin
            hi_q <= fix_rem;
            lo_q <= fix_quo;
        end else if (accept && !is_div) begin
            case (Op)
                OP_MTHI:            hi_q <= OpA;
                OP_MTLO:            lo_q <= OpA;
                OP_MULT, OP_MULTU:  {hi_q, lo_q} <= product;
                OP_MADD, OP_MADDU:  {hi_q, lo_q} <= acc + product;
                OP_MSUB, OP_MSUBU:  {hi_q, lo_q} <= acc - product;
                default: ;
            endcase
        end
    end

    // Completion covers single-cycle ops, divide-by-zero and an unflushed fix-up
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= (accept && (!is_div || div_zero)) || div_write;
            dbz_q  <= accept && is_div && div_zero;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign ReadHi    = hi_q;
    assign ReadLo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        Flush = 1'b0;
    logic        Busy, Done, DivByZero;
    logic [31:0] ReadHi, ReadLo;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Op        (Op),
        .OpA       (OpA),
        .OpB       (OpB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .ReadHi    (ReadHi),
        .ReadLo    (ReadLo)
    );

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ReadHi, ReadLo, Busy, Done, DivByZero} !== 67'd0) begin
            failures++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b dbz=%b want all zero", ReadHi, ReadLo, Busy, Done, DivByZero);
        end
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mt();
        issue(4'd0, 32'h12345678, 32'h0);
        checks++;
        if (Done !== 1'b1 || ReadHi !== 32'h12345678 || ReadLo !== 32'h0) begin
            failures++;
            $display("FAIL mthi got done=%b hi=%h lo=%h want 1 12345678 00000000", Done, ReadHi, ReadLo);
        end
        tick();
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL mthi_done_pulse got done=%b want 0", Done);
        end
        issue(4'd1, 32'h9ABCDEF0, 32'h0);
        checks++;
        if (Done !== 1'b1 || ReadHi !== 32'h12345678 || ReadLo !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL mtlo got done=%b hi=%h lo=%h want 1 12345678 9abcdef0", Done, ReadHi, ReadLo);
        end
    endtask

    task automatic test_mul();
        issue(4'd2, 32'hFFFFFFFF, 32'h2);
        checks++;
        if (ReadHi !== 32'hFFFFFFFF || ReadLo !== 32'hFFFFFFFE || Done !== 1'b1) begin
            failures++;
            $display("FAIL mult got hi=%h lo=%h done=%b want ffffffff fffffffe 1", ReadHi, ReadLo, Done);
        end
        issue(4'd3, 32'hFFFFFFFF, 32'h2);
        checks++;
        if (ReadHi !== 32'h1 || ReadLo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL multu got hi=%h lo=%h want 00000001 fffffffe", ReadHi, ReadLo);
        end
    endtask

    task automatic test_mac();
        issue(4'd0, 32'h0, 32'h0);
        issue(4'd1, 32'hFFFFFFFF, 32'h0);
        issue(4'd5, 32'h1, 32'h1);
        checks++;
        if (ReadHi !== 32'h1 || ReadLo !== 32'h0) begin
            failures++;
            $display("FAIL maddu_carry got hi=%h lo=%h want 00000001 00000000", ReadHi, ReadLo);
        end
        issue(4'd6, 32'h1, 32'h2);
        checks++;
        if (ReadHi !== 32'h0 || ReadLo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL msub_borrow got hi=%h lo=%h want 00000000 fffffffe", ReadHi, ReadLo);
        end
        issue(4'd4, 32'hFFFFFFFF, 32'h3);
        checks++;
        if (ReadHi !== 32'h0 || ReadLo !== 32'hFFFFFFFB) begin
            failures++;
            $display("FAIL madd_signed got hi=%h lo=%h want 00000000 fffffffb", ReadHi, ReadLo);
        end
    endtask

    task automatic test_div();
        int cycles;
        int busy_bad;
        issue(4'd8, 32'hFFFFFFF9, 32'h2);
        cycles = 0;
        busy_bad = 0;
        while (Done !== 1'b1 && cycles < 60) begin
            if (Busy !== 1'b1) busy_bad++;
            if (cycles == 5) begin
                Start = 1'b1; Op = 4'd0; OpA = 32'hDEADBEEF;
            end
            tick();
            Start = 1'b0;
            cycles++;
        end
        checks++;
        if (cycles != 33) begin
            failures++;
            $display("FAIL div_latency got %0d cycles want 33", cycles);
        end
        checks++;
        if (busy_bad != 0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL div_busy got %0d low cycles, busy_at_done=%b want 0 0", busy_bad, Busy);
        end
        checks++;
        if (ReadLo !== 32'hFFFFFFFD || ReadHi !== 32'hFFFFFFFF || DivByZero !== 1'b0) begin
            failures++;
            $display("FAIL div_neg got lo=%h hi=%h dbz=%b want fffffffd ffffffff 0", ReadLo, ReadHi, DivByZero);
        end
        issue(4'd8, 32'h80000000, 32'hFFFFFFFF);
        cycles = 0;
        while (Done !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
        checks++;
        if (ReadLo !== 32'h80000000 || ReadHi !== 32'h0 || cycles != 33) begin
            failures++;
            $display("FAIL div_overflow got lo=%h hi=%h cycles=%0d want 80000000 00000000 33", ReadLo, ReadHi, cycles);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        issue(4'd9, 32'd100, 32'd7);
        cycles = 0;
        while (Done !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
        checks++;
        if (ReadLo !== 32'd14 || ReadHi !== 32'd2) begin
            failures++;
            $display("FAIL divu_basic got lo=%h hi=%h want 0000000e 00000002", ReadLo, ReadHi);
        end
        issue(4'd1, 32'h00000055, 32'h0);
        checks++;
        if (Done !== 1'b1 || ReadLo !== 32'h55 || ReadHi !== 32'd2) begin
            failures++;
            $display("FAIL back_to_back got done=%b lo=%h hi=%h want 1 00000055 00000002", Done, ReadLo, ReadHi);
        end
    endtask

    task automatic test_divzero();
        issue(4'd9, 32'd10, 32'd0);
        checks++;
        if (Done !== 1'b1 || DivByZero !== 1'b1 || Busy !== 1'b0 || ReadLo !== 32'h55 || ReadHi !== 32'd2) begin
            failures++;
            $display("FAIL divzero got done=%b dbz=%b busy=%b lo=%h hi=%h want 1 1 0 00000055 00000002", Done, DivByZero, Busy, ReadLo, ReadHi);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || DivByZero !== 1'b0) begin
            failures++;
            $display("FAIL divzero_clear got done=%b dbz=%b want 0 0", Done, DivByZero);
        end
        issue(4'd12, 32'hFFFF0000, 32'h1234);
        checks++;
        if (Done !== 1'b1 || DivByZero !== 1'b0 || ReadLo !== 32'h55 || ReadHi !== 32'd2) begin
            failures++;
            $display("FAIL nop got done=%b dbz=%b lo=%h hi=%h want 1 0 00000055 00000002", Done, DivByZero, ReadLo, ReadHi);
        end
    endtask

    task automatic test_flush();
        int done_seen;
        issue(4'd9, 32'd1000, 32'd3);
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy got busy=%b want 0", Busy);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0 || ReadLo !== 32'h55 || ReadHi !== 32'd2) begin
            failures++;
            $display("FAIL flush_nodone got done_count=%0d lo=%h hi=%h want 0 00000055 00000002", done_seen, ReadLo, ReadHi);
        end
        Flush = 1'b1;
        issue(4'd0, 32'hCAFEF00D, 32'h0);
        Flush = 1'b0;
        checks++;
        if (Done !== 1'b0 || ReadHi !== 32'd2 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start got done=%b hi=%h busy=%b want 0 00000002 0", Done, ReadHi, Busy);
        end
    endtask

    task automatic test_reset_mid();
        issue(4'd9, 32'd50, 32'd5);
        repeat (5) tick();
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({ReadHi, ReadLo, Busy, Done, DivByZero} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b dbz=%b want all zero", ReadHi, ReadLo, Busy, Done, DivByZero);
        end
        tick();
        Rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (Busy !== 1'b0 || ReadLo !== 32'h0 || ReadHi !== 32'h0) begin
            failures++;
            $display("FAIL reset_discard got busy=%b lo=%h hi=%h want 0 00000000 00000000", Busy, ReadLo, ReadHi);
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mul();
        test_mac();
        test_div();
        test_back_to_back();
        test_divzero();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised HI/LO accumulator with integrated multiply, multiply-accumulate and iterative divide, sitting beside the ALU in the execute stage. It owns the architectural HI and LO registers. It performs MIPS MTHI/MTLO/MULT(U)/MADD(U)/MSUB(U)/DIV(U) on a start/busy/done handshake, and supports a flush that aborts an in-flight divide on exceptions.

## Interface
Parameters:
- WIDTH, 32: operand width and width of HI and LO each; accumulator is 2*WIDTH.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  operation request, sampled on Clk rising edge
- Op  in  4  operation code; encodings below
- OpA  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- OpB  in  WIDTH  rt operand (divisor / multiplier)
- Flush  in  1  abort in-flight divide
- Busy  out  1  divide in progress; Start ignored while high
- Done  out  1  one-cycle completion pulse
- DivByZero  out  1  valid with Done; divisor was zero
- ReadHi  out  WIDTH  current HI register
- ReadLo  out  WIDTH  current LO register

## Operation
- Op codes: 0 MTHI, 1 MTLO, 2 MULT, 3 MULTU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 DIV, 9 DIVU, 10-15 NOP.
- Accept = Start & !Busy & !Flush. Start while Busy is dropped silently, with no queueing.
- MTHI/MTLO: write OpA into HI or LO; the other register is unchanged.
- MULT(U): {HI,LO} <= OpA*OpB as a full 2*WIDTH product, signed or unsigned.
- MADD(U)/MSUB(U): {HI,LO} <= {HI,LO} ± product, modulo 2^(2*WIDTH). The carry from LO propagates into HI.
- DIV(U): LO <= quotient, HI <= remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed most-negative / -1 gives LO = most-negative and HI = 0.
  - Implementation: restoring divide on magnitudes, one quotient bit per cycle, sign fix-up in a final cycle.
- Divide by zero: no iteration. HI and LO stay unchanged; DivByZero=1 together with Done.
- NOP accepted: Done pulses and no register changes.
- State machine:
  - IDLE: accept a divide with nonzero OpB and go to DIV, loading magnitudes and counter=WIDTH-1.
  - DIV: one step per cycle; go to FIX when counter==0.
  - FIX: write HI/LO and go to IDLE.
  - All other ops complete from IDLE.
- Flush during DIV or FIX returns to IDLE at the next edge. HI and LO stay unchanged, with no Done.

## Timing
- Reset (async assert, sync-safe release): HI=LO=0, Busy=0, Done=0, DivByZero=0, state IDLE. Reset mid-divide discards the operation.
- ReadHi and ReadLo are driven directly from the registers and show the new values immediately after the writing edge.
- Single-cycle ops (MT*, MUL*, M*SUB*, NOP, div-by-zero) accepted at edge k:
  - HI/LO are written at edge k.
  - Done=1 during the cycle after edge k.
- Divide accepted at edge k:
  - Busy=1 from edge k until edge k+WIDTH+1.
  - HI/LO are written at edge k+WIDTH+1.
  - Done=1 during the cycle after edge k+WIDTH+1.
- Busy deasserts at the same edge Done asserts, so a new Start is accepted in the Done cycle.
- Flush in the same cycle as Start: Flush wins and the Start is dropped.
- Flush in IDLE has no effect.
- DivByZero is 0 whenever Done is 0.

## Structure
- Shared package hilo_pkg holds:
  - the Op encoding constants (OP_MTHI … OP_DIVU);
  - the state enum (ST_IDLE, ST_DIV, ST_FIX).
- Sub-module hilo_div_core holds the restoring-divide datapath (shift/subtract step, counter, magnitude remainder and quotient) with load/step/flush inputs. Sign handling and HI/LO writeback stay in the top.
- The multiplier is inferred as a single WIDTH×WIDTH→2*WIDTH product, with signed/unsigned selected by operand extension.

## Test plan
- Reset, then MTHI 0x12345678, MTLO 0x9ABCDEF0 → ReadHi=0x12345678, ReadLo=0x9ABCDEF0; Done pulses once per op.
- MULT 0xFFFFFFFF×0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Then MSUB 1×2 → HI=0, LO=0xFFFFFFFE.
- DIV -7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, Done exactly 33 cycles after accept.
  - Busy=1 throughout, and a Start during Busy is ignored.
  - DIV 0x80000000 ÷ -1 → LO=0x80000000, HI=0.
- DIVU 10 ÷ 0 → Done the next cycle with DivByZero=1; HI/LO unchanged.
- DIVU started, Flush at cycle 10 → Busy=0 next cycle, no Done, HI/LO unchanged. Rst_n pulsed mid-divide → all outputs zero immediately.
